// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and types for the compression core: round constants,
// initial hash value, FSM states and the rotate helper.
package sha256_pkg;

    localparam int unsigned WORD = 32;

    typedef logic [0:7][WORD-1:0] hvec_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_ADD
    } state_t;

    localparam logic [WORD-1:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam hvec_t H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [WORD-1:0] rotr(input logic [WORD-1:0] x, input int unsigned n);
        return (x >> n) | (x << (WORD - n));
    endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 round: next a..h from current a..h, schedule word and K.
module sha256_round
    import sha256_pkg::*;
(
    input  logic [8*WORD-1:0] i_s,
    input  logic [WORD-1:0]   i_w,
    input  logic [WORD-1:0]   i_k,
    output logic [8*WORD-1:0] o_s
);

    hvec_t           w_s;
    hvec_t           w_n;
    logic [WORD-1:0] w_sig0;
    logic [WORD-1:0] w_sig1;
    logic [WORD-1:0] w_ch;
    logic [WORD-1:0] w_maj;
    logic [WORD-1:0] w_t1;
    logic [WORD-1:0] w_t2;

    assign w_s    = i_s;
    assign w_sig0 = rotr(w_s[0], 2) ^ rotr(w_s[0], 13) ^ rotr(w_s[0], 22);
    assign w_sig1 = rotr(w_s[4], 6) ^ rotr(w_s[4], 11) ^ rotr(w_s[4], 25);
    assign w_ch   = (w_s[4] & w_s[5]) ^ (~w_s[4] & w_s[6]);
    assign w_maj  = (w_s[0] & w_s[1]) ^ (w_s[0] & w_s[2]) ^ (w_s[1] & w_s[2]);
    assign w_t1   = w_s[7] + w_sig1 + w_ch + i_k + i_w;
    assign w_t2   = w_sig0 + w_maj;

    always_comb begin
        w_n    = w_s;
        w_n[0] = w_t1 + w_t2;
        w_n[1] = w_s[0];
        w_n[2] = w_s[1];
        w_n[3] = w_s[2];
        w_n[4] = w_s[3] + w_t1;
        w_n[5] = w_s[4];
        w_n[6] = w_s[5];
        w_n[7] = w_s[6];
    end

    assign o_s = w_n;

endmodule

// File: rtl/sha256_compress_core.sv
// SHA-256 compression core fed with pre-expanded schedule beats (8 words per beat)
// through a small FIFO; one round per cycle, H chained across blocks until init.
module sha256_compress_core
    import sha256_pkg::*;
#(
    parameter int unsigned BUF_BEATS = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         init,
    input  logic         w_valid,
    input  logic [255:0] w_data,
    input  logic         w_last,
    output logic         w_ready,
    output logic         busy,
    output logic         digest_valid,
    output logic [255:0] digest
);

    localparam int unsigned PW = $clog2(BUF_BEATS);
    localparam int unsigned CW = $clog2(BUF_BEATS + 1);

    logic [256:0]    r_buf [0:BUF_BEATS-1];
    logic [PW-1:0]   r_wp;
    logic [PW-1:0]   r_rp;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_beat;
    state_t          r_state;
    state_t          w_nstate;
    logic [5:0]      r_rc;
    hvec_t           r_v;
    hvec_t           r_h;
    hvec_t           w_rnd;
    hvec_t           w_sum;
    logic            r_blk_last;
    logic [255:0]    r_digest;
    logic            r_dv;

    logic            w_push;
    logic            w_pop;
    logic            w_empty;
    logic            w_load;
    logic            w_step;
    logic            w_add;
    logic            w_init_ok;
    logic [256:0]    w_head;
    logic [2:0]      w_widx;
    logic [WORD-1:0] w_word;

    assign w_ready = (r_cnt < CW'(BUF_BEATS));
    assign w_empty = (r_cnt == '0);
    assign w_push  = w_valid && w_ready;
    assign w_head  = r_buf[r_rp];
    assign w_widx  = 3'd7 - r_rc[2:0];
    assign w_word  = w_head[{w_widx, 5'd0} +: WORD];

    // The last flag is only meaningful on beat 0; later beats store it cleared.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf[r_wp] <= {w_last && (r_beat == 3'd0), w_data};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wp   <= '0;
            r_rp   <= '0;
            r_cnt  <= '0;
            r_beat <= '0;
        end else begin
            if (w_push) begin
                r_wp   <= (r_wp == PW'(BUF_BEATS - 1)) ? '0 : r_wp + 1'b1;
                r_beat <= r_beat + 1'b1;
            end
            if (w_pop) begin
                r_rp <= (r_rp == PW'(BUF_BEATS - 1)) ? '0 : r_rp + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nstate;
        end
    end

    always_comb begin
        w_nstate = r_state;
        case (r_state)
            ST_IDLE:  if (!w_empty) w_nstate = ST_ROUND;
            ST_ROUND: if (w_step && r_rc == 6'd63) w_nstate = ST_ADD;
            ST_ADD:   w_nstate = ST_IDLE;
            default:  w_nstate = ST_IDLE;
        endcase
    end

    // A ROUND cycle without a head entry is a stall: nothing advances.
    always_comb begin
        w_load    = (r_state == ST_IDLE) && !w_empty;
        w_step    = (r_state == ST_ROUND) && !w_empty;
        w_pop     = w_step && (r_rc[2:0] == 3'd7);
        w_add     = (r_state == ST_ADD);
        w_init_ok = (r_state == ST_IDLE) && w_empty && init;
        busy      = (r_state != ST_IDLE) || !w_empty;
    end

    sha256_round u_round (
        .i_s (r_v),
        .i_w (w_word),
        .i_k (K[r_rc]),
        .o_s (w_rnd)
    );

    always_comb begin
        w_sum = r_h;
        for (int unsigned i = 0; i < 8; i++) begin
            w_sum[i] = r_h[i] + r_v[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rc       <= '0;
            r_v        <= '0;
            r_h        <= H0;
            r_blk_last <= 1'b0;
            r_digest   <= '0;
            r_dv       <= 1'b0;
        end else begin
            r_dv <= 1'b0;
            if (w_init_ok) begin
                r_h <= H0;
            end
            if (w_load) begin
                r_v  <= r_h;
                r_rc <= '0;
            end
            if (w_step) begin
                r_v  <= w_rnd;
                r_rc <= r_rc + 1'b1;
                if (r_rc == 6'd0) begin
                    r_blk_last <= w_head[256];
                end
            end
            if (w_add) begin
                r_h <= w_sum;
                if (r_blk_last) begin
                    r_digest <= w_sum;
                    r_dv     <= 1'b1;
                end
            end
        end
    end

    assign digest       = r_digest;
    assign digest_valid = r_dv;

endmodule

// File: tb/tb_sha256_compress_core.sv
// Randomised bench for sha256_compress_core against a full SHA-256 reference model
// (padding, schedule, compression) plus known-answer digests.
module tb_sha256_compress_core;

    localparam int unsigned BUF_BEATS = 2;

    typedef logic [0:7][31:0]  hv_t;
    typedef logic [0:15][31:0] blk_t;
    typedef logic [0:63][31:0] sch_t;

    localparam logic [31:0] TK [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam hv_t TH0 = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                           32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    localparam logic [255:0] KAT_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] KAT_NUL = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] KAT_TWO = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         init = 1'b0;
    logic         w_valid = 1'b0;
    logic [255:0] w_data = '0;
    logic         w_last = 1'b0;
    logic         w_ready;
    logic         busy;
    logic         digest_valid;
    logic [255:0] digest;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int          dv_count = 0;
    int unsigned dv_cyc = 0;
    int          stall_seen = 0;
    hv_t         mh = TH0;
    logic [7:0]  g_msg[$];
    blk_t        g_blks[$];

    sha256_compress_core #(.BUF_BEATS(BUF_BEATS)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .init         (init),
        .w_valid      (w_valid),
        .w_data       (w_data),
        .w_last       (w_last),
        .w_ready      (w_ready),
        .busy         (busy),
        .digest_valid (digest_valid),
        .digest       (digest)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (digest_valid) begin
            dv_count++;
            dv_cyc = cyc;
        end
        if (w_valid && !w_ready) stall_seen++;
    end

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic sch_t expand(input blk_t m);
        sch_t w;
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else begin
                s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
                s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
                w[t] = w[t-16] + s0 + w[t-7] + s1;
            end
        end
        return w;
    endfunction

    function automatic hv_t compress(input hv_t hin, input sch_t w);
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        hv_t r;
        for (int i = 0; i < 8; i++) v[i] = hin[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + TK[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[i] = hin[i] + v[i];
        return r;
    endfunction

    task automatic build_blocks();
        logic [7:0]  b[$];
        logic [63:0] bits;
        blk_t        blk;
        b = g_msg;
        bits = 64'(g_msg.size()) * 64'd8;
        b.push_back(8'h80);
        while (b.size() % 64 != 56) b.push_back(8'h00);
        for (int i = 7; i >= 0; i--) b.push_back(bits[i*8 +: 8]);
        g_blks.delete();
        for (int k = 0; k < b.size() / 64; k++) begin
            for (int j = 0; j < 16; j++)
                blk[j] = {b[64*k+4*j], b[64*k+4*j+1], b[64*k+4*j+2], b[64*k+4*j+3]};
            g_blks.push_back(blk);
        end
    endtask

    task automatic set_str(input string s);
        g_msg.delete();
        for (int i = 0; i < s.len(); i++) g_msg.push_back(s[i]);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin step(); n++; end
        if (busy) chk({tag, "_idle_timeout"}, 0, 1);
    endtask

    task automatic put_beat(input logic [255:0] d, input logic l, input logic ini, output int unsigned acc);
        int n = 0;
        w_valid = 1'b1; w_data = d; w_last = l; init = ini;
        @(negedge clk);
        while (!w_ready && n < 2000) begin @(negedge clk); n++; end
        if (!w_ready) chk("beat_accept_timeout", 0, 1);
        step();
        acc = cyc;
        w_valid = 1'b0; w_last = 1'b0; init = 1'b0;
    endtask

    function automatic logic [255:0] beat_of(input sch_t w, input int b);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[255-32*k -: 32] = w[8*b+k];
        return d;
    endfunction

    task automatic run_msg(input string tag, input bit use_init, input bit init_same, input int max_gap,
                           input bit mid_init, input bit has_kat, input logic [255:0] kat);
        hv_t         h;
        sch_t        w;
        int          dv0, n;
        int unsigned acc, acc0;
        logic        lf;
        build_blocks();
        wait_idle(tag);
        h = use_init ? TH0 : mh;
        if (use_init && !init_same) begin
            init = 1'b1; step(); init = 1'b0;
        end
        dv0 = dv_count;
        acc0 = 0;
        for (int bi = 0; bi < g_blks.size(); bi++) begin
            w = expand(g_blks[bi]);
            h = compress(h, w);
            for (int b = 0; b < 8; b++) begin
                if (max_gap > 0) repeat ($urandom_range(0, max_gap)) step();
                lf = (b == 0) ? (bi == g_blks.size() - 1) : 1'($urandom_range(0, 1));
                put_beat(beat_of(w, b), lf, use_init && init_same && bi == 0 && b == 0, acc);
                if (bi == 0 && b == 0) acc0 = acc;
            end
        end
        mh = h;
        if (mid_init) begin
            chk({tag, "_midinit_busy"}, busy, 1);
            init = 1'b1; step(); init = 1'b0;
        end
        n = 0;
        while (dv_count < dv0 + 1 && n < 3000) begin step(); n++; end
        if (dv_count < dv0 + 1) chk({tag, "_dv_timeout"}, 0, 1);
        chk({tag, "_digest"}, digest, h);
        if (has_kat) chk({tag, "_kat"}, digest, kat);
        if (g_blks.size() == 1 && max_gap == 0)
            chk({tag, "_latency"}, dv_cyc - acc0, 66);
        wait_idle(tag);
        repeat (5) step();
        chk({tag, "_pulses"}, dv_count - dv0, 1);
        chk({tag, "_digest_hold"}, digest, h);
    endtask

    initial begin
        int          st0, dv0, n;
        int unsigned acc, acc0;
        sch_t        w;

        repeat (3) step();
        chk("rst_digest", digest, 0);
        chk("rst_dv", digest_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", w_ready, 1);
        rst_n = 1'b1;
        step();

        st0 = stall_seen;
        set_str("abc");
        run_msg("abc", 1, 0, 0, 0, 1, KAT_ABC);
        chk("abc_backpressure", (stall_seen > st0), 1);

        g_msg.delete();
        run_msg("empty", 1, 1, 0, 0, 1, KAT_NUL);

        g_msg.delete();
        for (int i = 0; i < 14; i++)
            for (int j = 0; j < 4; j++) g_msg.push_back(8'(8'h61 + i + j));
        run_msg("two_blk", 1, 0, 0, 1, 1, KAT_TWO);

        set_str("abc");
        run_msg("abc_sparse", 1, 0, 6, 0, 1, KAT_ABC);

        set_str("abc");
        run_msg("abc_sameinit", 1, 1, 0, 0, 1, KAT_ABC);

        g_msg.delete();
        repeat (20) g_msg.push_back(8'($urandom));
        run_msg("chain", 0, 0, 2, 0, 0, '0);

        // Mid-block reset: abc beats 0..3 only, reset around round 30
        wait_idle("rstmid");
        set_str("abc");
        build_blocks();
        w = expand(g_blks[0]);
        init = 1'b1; step(); init = 1'b0;
        dv0 = dv_count;
        acc0 = 0;
        for (int b = 0; b < 4; b++) begin
            put_beat(beat_of(w, b), b == 0, 1'b0, acc);
            if (b == 0) acc0 = acc;
        end
        n = 0;
        while (cyc < acc0 + 31 && n < 200) begin step(); n++; end
        chk("rstmid_busy", busy, 1);
        rst_n = 1'b0;
        repeat (2) step();
        chk("rstmid_digest", digest, 0);
        chk("rstmid_busy_clr", busy, 0);
        chk("rstmid_ready", w_ready, 1);
        rst_n = 1'b1;
        repeat (80) step();
        chk("rstmid_no_pulse", dv_count - dv0, 0);
        set_str("abc");
        run_msg("abc_after_rst", 1, 0, 0, 0, 1, KAT_ABC);

        for (int it = 0; it < 6; it++) begin
            g_msg.delete();
            repeat ($urandom_range(0, 130)) g_msg.push_back(8'($urandom));
            run_msg($sformatf("rand%0d", it), (it != 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), 0, 0, '0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
